// File: rtl/vga_timing_pkg.sv
// VGA raster timing constants and phase encoding shared by the sync generator.
// Defaults describe 640x480@60 with a 25 MHz pixel rate.
package vga_timing_pkg;

  localparam int H_VISIBLE_D = 640;
  localparam int H_FRONT_D   = 16;
  localparam int H_SYNC_D    = 96;
  localparam int H_BACK_D    = 48;
  localparam int H_TOTAL_D   =
    H_VISIBLE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;

  localparam int V_VISIBLE_D = 480;
  localparam int V_FRONT_D   = 10;
  localparam int V_SYNC_D    = 2;
  localparam int V_BACK_D    = 33;
  localparam int V_TOTAL_D   =
    V_VISIBLE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;

  localparam int CLK_DIV_D = 2;
  localparam int COORD_W_D = 10;

  typedef enum logic [1:0] {
    ACT = 2'd0,
    FP  = 2'd1,
    SY  = 2'd2,
    BP  = 2'd3
  } phase_e;

  function automatic int axis_total(
    input int vis,
    input int front,
    input int sync,
    input int back
  );
    return vis + front + sync + back;
  endfunction

endpackage

// File: rtl/contador_eje.sv
// One raster axis: position counter plus visible/porch/sync phase tracker.
// `phase` reports the phase the axis holds after the current edge.
module contador_eje
  import vga_timing_pkg::*;
#(
  parameter int W       = COORD_W_D,
  parameter int VISIBLE = H_VISIBLE_D,
  parameter int FRONT   = H_FRONT_D,
  parameter int SYNC    = H_SYNC_D,
  parameter int BACK    = H_BACK_D
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv,
  output logic [W-1:0] count,
  output phase_e       phase,
  output logic         wrap
);

  localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

  localparam logic [W-1:0] LAST_ACT = W'(VISIBLE - 1);
  localparam logic [W-1:0] LAST_FP  = W'(VISIBLE + FRONT - 1);
  localparam logic [W-1:0] LAST_SY  = W'(VISIBLE + FRONT + SYNC - 1);
  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);

  logic [W-1:0] count_q, count_d;
  phase_e       phase_q, phase_d;
  logic         wrap_d;

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    wrap_d  = adv && (count_q == LAST);
    if (adv) begin
      count_d = wrap_d ? '0 : count_q + 1'b1;
      case (phase_q)
        ACT: if (count_q == LAST_ACT) phase_d = FP;
        FP:  if (count_q == LAST_FP)  phase_d = SY;
        SY:  if (count_q == LAST_SY)  phase_d = BP;
        BP:  if (wrap_d)              phase_d = ACT;
        default:                      phase_d = ACT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      phase_q <= ACT;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count = count_q;
  assign phase = phase_d;
  assign wrap  = wrap_d;

endmodule

// File: rtl/control_de_sincronia.sv
// VGA sync generator: pixel-rate divider, H/V raster counters and
// registered sync/blank/coordinate outputs that all describe one pixel.
module control_de_sincronia
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_D,
  parameter int H_VISIBLE = H_VISIBLE_D,
  parameter int H_FRONT   = H_FRONT_D,
  parameter int H_SYNC    = H_SYNC_D,
  parameter int H_BACK    = H_BACK_D,
  parameter int V_VISIBLE = V_VISIBLE_D,
  parameter int V_FRONT   = V_FRONT_D,
  parameter int V_SYNC    = V_SYNC_D,
  parameter int V_BACK    = V_BACK_D,
  parameter bit SYNC_POL  = 1'b0,
  parameter int COORD_W   = COORD_W_D
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pixel_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             adv;

  logic               h_wrap, v_wrap, v_adv;
  phase_e             h_phase, v_phase;
  logic [COORD_W-1:0] h_count, v_count;

  logic tick_q, tick_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic blank_q, blank_d;
  logic line_q, line_d;
  logic frame_q, frame_d;

  assign adv   = (div_q == DIV_LAST);
  assign v_adv = adv & h_wrap;

  contador_eje #(
    .W       (COORD_W),
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h (
    .clk   (clk),
    .reset (reset),
    .adv   (adv),
    .count (h_count),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  contador_eje #(
    .W       (COORD_W),
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v (
    .clk   (clk),
    .reset (reset),
    .adv   (v_adv),
    .count (v_count),
    .phase (v_phase),
    .wrap  (v_wrap)
  );

  // Outputs register the next-state phases so they land with the counters.
  always_comb begin
    div_d   = adv ? '0 : div_q + 1'b1;
    tick_d  = adv;
    hsync_d = (h_phase == SY) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (v_phase == SY) ? SYNC_POL : ~SYNC_POL;
    blank_d = (h_phase != ACT) || (v_phase != ACT);
    line_d  = h_wrap;
    frame_d = v_wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      blank_q <= 1'b1;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      blank_q <= blank_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign pixel_tick  = tick_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign pixel_x     = h_count;
  assign pixel_y     = v_count;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_control_de_sincronia.sv
// Directed bench for control_de_sincronia over four timing configurations.
// Expected values are hand-derived from the raster geometry of each config.
module tb_control_de_sincronia;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;

  logic       tk_a, hs_a, vs_a, bl_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       tk_b, hs_b, vs_b, bl_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;
  logic       tk_c, hs_c, vs_c, bl_c, ls_c, fs_c;
  logic [3:0] x_c, y_c;
  logic       tk_d, hs_d, vs_d, bl_d, ls_d, fs_d;
  logic [5:0] x_d, y_d;

  control_de_sincronia u_a (
    .clk(clk), .reset(rst_a), .pixel_tick(tk_a),
    .hsync(hs_a), .vsync(vs_a), .blank(bl_a),
    .pixel_x(x_a), .pixel_y(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  control_de_sincronia #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_b (
    .clk(clk), .reset(rst_b), .pixel_tick(tk_b),
    .hsync(hs_b), .vsync(vs_b), .blank(bl_b),
    .pixel_x(x_b), .pixel_y(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  control_de_sincronia #(
    .CLK_DIV(1),
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .COORD_W(4)
  ) u_c (
    .clk(clk), .reset(rst_c), .pixel_tick(tk_c),
    .hsync(hs_c), .vsync(vs_c), .blank(bl_c),
    .pixel_x(x_c), .pixel_y(y_c),
    .line_start(ls_c), .frame_start(fs_c)
  );

  control_de_sincronia #(
    .CLK_DIV(2),
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .COORD_W(6)
  ) u_d (
    .clk(clk), .reset(rst_d), .pixel_tick(tk_d),
    .hsync(hs_d), .vsync(vs_d), .blank(bl_d),
    .pixel_x(x_d), .pixel_y(y_d),
    .line_start(ls_d), .frame_start(fs_d)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int hs_cnt, ls_cnt, ls_clk, rise_x, nontick;
    int ls1, ls2, hs_x;
    int vs_cnt, vs_y, fs_cnt, fs_clk, xm, ym;
    logic prev_bl, found;

    #12;
    chk("a_reset", {tk_a, hs_a, vs_a, bl_a, ls_a, fs_a, x_a, y_a},
        {6'b011100, 10'd0, 10'd0});
    chk("b_reset", {tk_b, hs_b, vs_b, bl_b, ls_b, fs_b},
        6'b000100);

    // Default config: divider cadence and first pixels.
    @(negedge clk);
    rst_a = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("a_tick", tk_a, (k % 2) == 0);
      chk("a_x", x_a, k / 2);
    end
    chk("a_vis", {bl_a, hs_a, vs_a}, 3'b011);

    // Default config: rest of the first line.
    hs_cnt = 0; ls_cnt = 0; ls_clk = 0; rise_x = -1;
    prev_bl = bl_a;
    for (int k = 21; k <= 1600; k++) begin
      @(negedge clk);
      if (!hs_a) hs_cnt++;
      if (bl_a && !prev_bl && rise_x < 0) rise_x = int'(x_a);
      prev_bl = bl_a;
      if (ls_a) begin
        ls_cnt++;
        ls_clk = k;
        chk("a_ls_tick", tk_a, 1);
      end
    end
    chk("a_hs_len", hs_cnt, 192);
    chk("a_blank_x", rise_x, 640);
    chk("a_ls_cnt", ls_cnt, 1);
    chk("a_ls_clk", ls_clk, 1600);
    chk("a_line1", {x_a, y_a, bl_a}, {10'd0, 10'd1, 1'b0});
    rst_a = 1'b1;

    // Active-high sync, undivided clock.
    @(negedge clk);
    rst_b = 1'b0;
    nontick = 0; hs_cnt = 0; hs_x = -1; ls1 = 0; ls2 = 0;
    for (int k = 1; k <= 1600; k++) begin
      @(negedge clk);
      if (!tk_b) nontick++;
      if (k <= 800 && hs_b) begin
        hs_cnt++;
        if (hs_x < 0) hs_x = int'(x_b);
      end
      if (ls_b) begin
        if (ls1 == 0) ls1 = k;
        else if (ls2 == 0) ls2 = k;
      end
    end
    chk("b_nontick", nontick, 0);
    chk("b_hs_len", hs_cnt, 96);
    chk("b_hs_x", hs_x, 656);
    chk("b_ls1", ls1, 800);
    chk("b_period", ls2 - ls1, 800);
    rst_b = 1'b1;

    // Tiny raster, one full frame checked pixel by pixel.
    @(negedge clk);
    rst_c = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      int ex, ey;
      logic [12:0] expv;
      @(negedge clk);
      ex = k % 8;
      ey = (k / 8) % 6;
      expv = {ex[3:0], ey[3:0],
              (ex >= 4) || (ey >= 3),
              !(ex == 5 || ex == 6),
              !(ey == 4),
              ex == 0,
              ex == 0 && ey == 0};
      chk("c_scan", {x_c, y_c, bl_c, hs_c, vs_c, ls_c, fs_c}, expv);
    end
    rst_c = 1'b1;

    // Mid-size raster: full frame, then a reset inside sync.
    @(negedge clk);
    rst_d = 1'b0;
    vs_cnt = 0; vs_y = -1; fs_cnt = 0; fs_clk = 0;
    for (int k = 1; k <= 576; k++) begin
      @(negedge clk);
      xm = (k / 2) % 24;
      ym = (k / 48) % 12;
      chk("d_scan", {x_d, y_d, bl_d},
          {xm[5:0], ym[5:0], (xm >= 16) || (ym >= 6)});
      if (!vs_d) begin
        vs_cnt++;
        if (vs_y < 0) vs_y = int'(y_d);
      end
      if (fs_d) begin
        fs_cnt++;
        fs_clk = k;
      end
    end
    chk("d_vs_len", vs_cnt, 96);
    chk("d_vs_y", vs_y, 8);
    chk("d_fs_cnt", fs_cnt, 1);
    chk("d_fs_clk", fs_clk, 576);

    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(negedge clk);
      if (x_d == 6'd19 && y_d == 6'd8) found = 1'b1;
    end
    chk("d_reach", found, 1);
    chk("d_in_sync", {hs_d, vs_d}, 2'b00);
    rst_d = 1'b1;
    #1;
    chk("d_async_rst",
        {hs_d, vs_d, bl_d, tk_d, ls_d, fs_d, x_d, y_d},
        {6'b111000, 6'd0, 6'd0});

    @(negedge clk);
    rst_d = 1'b0;
    fs_clk = -1;
    for (int k = 1; k <= 2000 && fs_clk < 0; k++) begin
      @(negedge clk);
      if (fs_d) fs_clk = k;
    end
    chk("d_fs_after_rst", fs_clk, 576);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
